// File: rtl/vga_pkg.sv
// vga_pkg: shared types and constants for the VGA
// display fetch path.
package vga_pkg;
  localparam int ADDR_W = 26;
  localparam logic [3:0] VGA_MASTER_ID = 4'd2;
  localparam int BURST_WORDS_DEF = 8;
  localparam int BURST_BYTES = BURST_WORDS_DEF * 4;
  localparam int FRAME_WORDS_DEF = 76800;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    REQ,
    DATA,
    DONE
  } state_t;
endpackage

// File: rtl/vga_line_fifo.sv
// vga_line_fifo: synchronous first-word-fall-through
// FIFO; flush has priority over push and pop.
module vga_line_fifo #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [31:0]   wdata,
  input  logic          pop,
  input  logic          flush,
  output logic [31:0]   rdata,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/vga_fetch_scheduler.sv
// vga_fetch_scheduler: issues whole-burst SDRAM reads
// for the display and buffers the words for the pixel pipe.
module vga_fetch_scheduler
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH  = 64,
  parameter int BURST_WORDS = BURST_WORDS_DEF,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              vga_request,
  output logic [ADDR_W-1:0] vga_address,
  input  logic              vga_ack,
  input  logic              vga_valid,
  input  logic [31:0]       vga_rdata,
  input  logic              vga_complete,
  input  logic              pixel_pop,
  output logic [31:0]       pixel_data,
  output logic              fifo_empty,
  output logic [LW-1:0]     fifo_level,
  output logic              underrun,
  output logic              burst_error
);

  localparam int WL_W = $clog2(FRAME_WORDS + 1);
  localparam int BC_W = $clog2(BURST_WORDS + 1) + 1;
  localparam logic [ADDR_W-1:0] STEP =
    ADDR_W'(BURST_WORDS * 4);

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] base_al;
  logic [WL_W-1:0]   words_left;
  logic [BC_W-1:0]   beat_cnt;
  logic [BC_W-1:0]   beat_next;
  logic              discard;
  logic              restart;
  logic              push;
  logic              room;
  logic              fifo_full;
  logic              unused_bits;

  assign base_al     = {frame_base[ADDR_W-1:5], 5'b0};
  assign unused_bits = ^frame_base[4:0];
  assign restart     = frame_start &&
    ((state == IDLE || state == DONE) ? enable : 1'b1);
  assign push        = (state == DATA) && vga_valid && !discard;
  assign room        = ({1'b0, fifo_level} + (LW+1)'(BURST_WORDS))
                       <= (LW+1)'(FIFO_DEPTH);
  assign beat_next   = beat_cnt + BC_W'(vga_valid);

  vga_line_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (vga_rdata),
    .pop   (pixel_pop),
    .flush (restart),
    .rdata (pixel_data),
    .level (fifo_level),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clock) begin
    if (!reset)
      assert (!(push && fifo_full && !pixel_pop));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      vga_request <= 1'b0;
      vga_address <= '0;
      cur_addr    <= '0;
      words_left  <= '0;
      beat_cnt    <= '0;
      discard     <= 1'b0;
      underrun    <= 1'b0;
      burst_error <= 1'b0;
    end else begin
      if (frame_start)
        underrun <= 1'b0;
      else if (pixel_pop && fifo_empty)
        underrun <= 1'b1;
      if (restart) begin
        cur_addr   <= base_al;
        words_left <= WL_W'(FRAME_WORDS);
      end
      unique case (state)
        IDLE, DONE: begin
          if (restart)
            state <= ARM;
        end
        ARM: begin
          if (!restart) begin
            if (words_left == '0) begin
              state <= DONE;
            end else if (enable && room) begin
              state       <= REQ;
              vga_request <= 1'b1;
              vga_address <= cur_addr;
            end
          end
        end
        REQ: begin
          if (restart)
            discard <= 1'b1;
          if (vga_ack) begin
            state       <= DATA;
            vga_request <= 1'b0;
            if (!restart) begin
              cur_addr   <= cur_addr + STEP;
              words_left <= words_left - WL_W'(BURST_WORDS);
            end
          end
        end
        DATA: begin
          beat_cnt <= beat_next;
          if (vga_complete) begin
            if (beat_next != BC_W'(BURST_WORDS))
              burst_error <= 1'b1;
            beat_cnt <= '0;
            discard  <= 1'b0;
            state    <= ARM;
          end else if (restart) begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fetch_scheduler.sv
// tb_vga_fetch_scheduler: directed table plus corner
// sequences against a simple arbiter/SDRAM responder.
module tb_vga_fetch_scheduler;

  localparam int FW = 96;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic [25:0] frame_base = '0;
  logic        vga_request;
  logic [25:0] vga_address;
  logic        vga_ack = 1'b0;
  logic        vga_valid = 1'b0;
  logic [31:0] vga_rdata = '0;
  logic        vga_complete = 1'b0;
  logic        pixel_pop = 1'b0;
  logic [31:0] pixel_data;
  logic        fifo_empty;
  logic [6:0]  fifo_level;
  logic        underrun;
  logic        burst_error;

  always #5 clock = ~clock;

  vga_fetch_scheduler #(
    .FIFO_DEPTH  (64),
    .BURST_WORDS (8),
    .FRAME_WORDS (FW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .frame_start  (frame_start),
    .frame_base   (frame_base),
    .vga_request  (vga_request),
    .vga_address  (vga_address),
    .vga_ack      (vga_ack),
    .vga_valid    (vga_valid),
    .vga_rdata    (vga_rdata),
    .vga_complete (vga_complete),
    .pixel_pop    (pixel_pop),
    .pixel_data   (pixel_data),
    .fifo_empty   (fifo_empty),
    .fifo_level   (fifo_level),
    .underrun     (underrun),
    .burst_error  (burst_error)
  );

  int tests = 0;
  int fails = 0;

  bit          s_busy = 1'b0;
  int          s_beat = 0;
  int          s_nbeats = 8;
  logic [25:0] s_addr = '0;
  logic [25:0] last_addr = '0;
  int          req_cnt = 0;
  int          prot_viol = 0;
  int          pop_left = 0;
  bit          force_pop = 1'b0;
  logic [31:0] exp_pix = '0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // responder: acks immediately, streams words whose value
  // is their own byte address, last word with complete
  task automatic tick();
    @(posedge clock);
    #1;
    vga_valid    = 1'b0;
    vga_complete = 1'b0;
    if (vga_ack) begin
      vga_ack = 1'b0;
    end else if (s_busy) begin
      vga_valid = 1'b1;
      vga_rdata = {6'b0, s_addr} + 32'(4 * s_beat);
      if (s_beat == s_nbeats - 1) begin
        vga_complete = 1'b1;
        s_busy       = 1'b0;
      end
      s_beat++;
    end else if (vga_request) begin
      vga_ack   = 1'b1;
      s_busy    = 1'b1;
      s_beat    = 0;
      s_addr    = vga_address;
      last_addr = vga_address;
      req_cnt++;
    end
    if (vga_request && s_busy && !vga_ack)
      prot_viol++;
    pixel_pop = 1'b0;
    if (force_pop) begin
      pixel_pop = 1'b1;
    end else if (pop_left > 0 && !fifo_empty) begin
      check("pixel_data", pixel_data, exp_pix);
      exp_pix   = exp_pix + 32'd4;
      pop_left--;
      pixel_pop = 1'b1;
    end
  endtask

  typedef struct {
    int          pops;
    int          cycles;
    int          exp_reqs;
    int          exp_level;
    logic [25:0] exp_addr;
  } phase_t;

  phase_t ph[6];

  initial begin
    int n;
    int r0;

    ph[0] = '{0,   150, 8,  64, 26'h01000E0};
    ph[1] = '{8,   60,  9,  64, 26'h0100100};
    ph[2] = '{4,   60,  9,  60, 26'h0100100};
    ph[3] = '{4,   60,  10, 64, 26'h0100120};
    ph[4] = '{200, 250, 12, 0,  26'h0100160};
    ph[5] = '{0,   50,  12, 0,  26'h0100160};

    repeat (3) tick();
    check("rst_request", vga_request, 0);
    check("rst_address", vga_address, 0);
    check("rst_level", fifo_level, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_underrun", underrun, 0);
    check("rst_burst_error", burst_error, 0);

    reset       = 1'b0;
    enable      = 1'b1;
    frame_base  = 26'h0100000;
    exp_pix     = 32'h0100000;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;

    for (int i = 0; i < 6; i++) begin
      pop_left = ph[i].pops;
      repeat (ph[i].cycles) tick();
      pop_left = 0;
      check($sformatf("ph%0d_reqs", i), req_cnt, ph[i].exp_reqs);
      check($sformatf("ph%0d_level", i), fifo_level,
            ph[i].exp_level);
      check($sformatf("ph%0d_addr", i), vga_address,
            ph[i].exp_addr);
    end
    check("no_error_yet", burst_error, 0);

    force_pop = 1'b1;
    tick();
    force_pop = 1'b0;
    tick();
    check("underrun_set", underrun, 1);
    repeat (3) tick();
    check("underrun_sticky", underrun, 1);
    check("underrun_level", fifo_level, 0);
    check("underrun_empty", fifo_empty, 1);

    frame_base  = 26'h0200000;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("underrun_clear", underrun, 0);

    n = 0;
    while (!(s_busy && s_beat == 3) && n < 100) begin
      tick();
      n++;
    end
    check("wait_beat3", n < 100, 1);
    tick();
    check("mid_level3", fifo_level, 3);

    frame_base  = 26'h030005C;
    exp_pix     = 32'h0300040;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("flush_empty", fifo_empty, 1);
    check("flush_level", fifo_level, 0);

    r0 = req_cnt;
    n  = 0;
    while (req_cnt == r0 && n < 100) begin
      tick();
      n++;
    end
    check("wait_new_req", n < 100, 1);
    check("discard_level", fifo_level, 0);
    check("new_base_addr", last_addr, 26'h0300040);
    check("discard_no_err", burst_error, 0);

    s_nbeats = 7;
    n = 0;
    while (s_busy && n < 100) begin
      tick();
      n++;
    end
    check("wait_short", n < 100, 1);
    tick();
    s_nbeats = 8;
    check("short_error", burst_error, 1);
    check("short_level", fifo_level, 7);

    r0 = req_cnt;
    n  = 0;
    while (req_cnt == r0 && n < 100) begin
      tick();
      n++;
    end
    check("wait_after_err", n < 100, 1);
    check("after_err_addr", last_addr, 26'h0300060);

    pop_left = 7;
    repeat (20) tick();
    check("short_popped", pop_left, 0);
    pop_left = 0;
    check("error_sticky", burst_error, 1);
    check("protocol", prot_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
